// File: rtl/memory1_stage_pkg.sv
// Shared types for the first memory stage: stage payloads, D-cache request,
// access size encoding and the alignment exception code.
package memory1_stage_pkg;

    localparam logic [5:0] ECODE_ALE = 6'h09;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } byte_type_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] pc_plus4;
        logic [31:0] ex_out;
        logic [31:0] rkd;
        logic        is_mem;
        logic        is_store;
        logic        is_signed;
        logic        is_cac;
        byte_type_t  byte_type;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wdata;
        logic [2:0]  tlb_op;
        logic        is_ertn;
    } execute_memory1_pass_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
    } excp_pass_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] pc_plus4;
        logic [31:0] ex_out;
        logic        is_mem;
        logic        is_store;
        logic        is_signed;
        byte_type_t  byte_type;
        logic [1:0]  addr_lo;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wdata;
        logic [2:0]  tlb_op;
        logic        is_ertn;
        logic        mem_issued;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic        data_valid;
        logic [31:0] data;
    } forward_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        is_store;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        is_cac;
    } dcache_req_t;

endpackage

// File: rtl/memory1_stage_mem_align.sv
// Access-size decode: byte strobe, lane-replicated store data and the
// misalignment flag. Pure combinational; memory2 uses the same lane encoding.
module mem_align
    import memory1_stage_pkg::*;
(
    input  byte_type_t  byte_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rkd,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Decode strobe/data/alignment from size and low address bits.
    always_comb begin
        wstrb      = 4'b1111;
        wdata      = rkd;
        misaligned = |addr_lo;
        case (byte_type)
            BYTE: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata      = {4{rkd[7:0]}};
                misaligned = 1'b0;
            end
            HALF: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata      = {2{rkd[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                wstrb      = 4'b1111;
                wdata      = rkd;
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/memory1_stage.sv
// First memory stage: stage register, alignment check, D-cache request
// issue over valid/ready, single-issue tracking under downstream stall,
// and the forwarding source for decode.
module memory1_stage
    import memory1_stage_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter logic [5:0] ECODE_ALE = memory1_stage_pkg::ECODE_ALE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  stall_i,
    output logic                  stall_o,
    input  execute_memory1_pass_t pass_in,
    input  excp_pass_t            excp_pass_in,
    output memory1_memory2_pass_t pass_out,
    output excp_pass_t            excp_pass_out,
    output forward_req_t          fwd_req,
    output dcache_req_t           dc_req,
    input  logic                  dc_ready
);

    execute_memory1_pass_t pass_in_r;
    excp_pass_t            excp_pass_in_r;
    logic                  issued;

    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              misaligned;
    logic              ale;
    logic              any_excp;
    logic              mem_do;
    logic              req_valid;
    logic              handshake;
    logic              dc_wait;

    assign addr = pass_in_r.ex_out[ADDR_W-1:0];

    mem_align u_mem_align (
        .byte_type  (pass_in_r.byte_type),
        .addr_lo    (addr[1:0]),
        .rkd        (pass_in_r.rkd),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .misaligned (misaligned)
    );

    // An exception from an earlier stage masks the alignment check.
    assign ale       = pass_in_r.valid & pass_in_r.is_mem & ~excp_pass_in_r.valid & misaligned;
    assign any_excp  = excp_pass_in_r.valid | ale;
    assign mem_do    = pass_in_r.valid & pass_in_r.is_mem & ~any_excp;
    assign req_valid = mem_do & ~issued;
    assign handshake = req_valid & dc_ready;
    assign dc_wait   = req_valid & ~dc_ready;
    assign stall_o   = stall_i | dc_wait;

    // Stage register; fully cleared on reset so every output reads zero,
    // only the valid bits are dropped on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_in_r      <= '0;
            excp_pass_in_r <= '0;
        end else if (flush_i) begin
            pass_in_r.valid      <= 1'b0;
            excp_pass_in_r.valid <= 1'b0;
        end else if (!stall_o) begin
            pass_in_r      <= pass_in;
            excp_pass_in_r <= excp_pass_in;
        end
    end

    // Remember an accepted request while memory2 holds the stage so it is
    // never sent twice.
    always_ff @(posedge clk) begin
        if (rst || flush_i || !stall_o) begin
            issued <= 1'b0;
        end else if (handshake) begin
            issued <= 1'b1;
        end
    end

    // D-cache request; payload held at zero while the stage is empty.
    always_comb begin
        dc_req = '0;
        if (pass_in_r.valid) begin
            dc_req.addr     = 32'(addr);
            dc_req.is_store = pass_in_r.is_store;
            dc_req.wstrb    = wstrb;
            dc_req.wdata    = wdata;
            dc_req.is_cac   = pass_in_r.is_cac;
        end
        dc_req.valid = req_valid;
    end

    // Payload and exception info towards memory2.
    always_comb begin
        pass_out                   = '0;
        pass_out.valid             = pass_in_r.valid & ~stall_o;
        pass_out.pc                = pass_in_r.pc;
        pass_out.rd                = pass_in_r.rd;
        pass_out.is_wr_rd          = pass_in_r.is_wr_rd;
        pass_out.is_wr_rd_pc_plus4 = pass_in_r.is_wr_rd_pc_plus4;
        pass_out.pc_plus4          = pass_in_r.pc_plus4;
        pass_out.ex_out            = pass_in_r.ex_out;
        pass_out.is_mem            = pass_in_r.is_mem;
        pass_out.is_store          = pass_in_r.is_store;
        pass_out.is_signed         = pass_in_r.is_signed;
        pass_out.byte_type         = pass_in_r.byte_type;
        pass_out.addr_lo           = addr[1:0];
        pass_out.csr_we            = pass_in_r.csr_we;
        pass_out.csr_num           = pass_in_r.csr_num;
        pass_out.csr_wdata         = pass_in_r.csr_wdata;
        pass_out.tlb_op            = pass_in_r.tlb_op;
        pass_out.is_ertn           = pass_in_r.is_ertn;
        pass_out.mem_issued        = issued | handshake;

        excp_pass_out = excp_pass_in_r;
        if (ale) begin
            excp_pass_out.valid    = 1'b1;
            excp_pass_out.ecode    = ECODE_ALE;
            excp_pass_out.esubcode = '0;
            excp_pass_out.badv     = 32'(addr);
        end
        excp_pass_out.valid = excp_pass_out.valid & pass_out.valid;
    end

    // Forwarding source; loads cannot supply data until memory2.
    always_comb begin
        fwd_req            = '0;
        fwd_req.valid      = pass_in_r.valid & pass_in_r.is_wr_rd & (pass_in_r.rd != 5'd0) & ~any_excp;
        fwd_req.idx        = pass_in_r.rd;
        fwd_req.data_valid = pass_in_r.valid & ~(pass_in_r.is_mem & ~pass_in_r.is_store);
        fwd_req.data       = pass_in_r.is_wr_rd_pc_plus4 ? pass_in_r.pc_plus4 : pass_in_r.ex_out;
    end

endmodule

// File: doc/memory1_stage.md
# memory1_stage

First memory stage of the in-order pipeline. It sits directly downstream of the execute stage and consumes `execute_memory1_pass_t` and `excp_pass_t`. It checks load/store alignment and raises ALE, then builds the byte strobe and replicated store data. It issues the D-cache request over a valid/ready handshake and forwards its result to decode. Its output feeds memory2, which receives the cache response.

## Interface
Parameters:
- `ADDR_W`, 32: virtual address width.
- `ECODE_ALE`, 6'h09: exception code written on misalignment.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `flush_i`  in  1  clear the stage register
- `stall_i`  in  1  downstream (memory2) stall
- `stall_o`  out  1  stall to execute; equals `stall_i | dc_wait`
- `pass_in`  in  `execute_memory1_pass_t`  payload from execute
- `excp_pass_in`  in  `excp_pass_t`  exception info from execute
- `pass_out`  out  `memory1_memory2_pass_t`  payload to memory2
- `excp_pass_out`  out  `excp_pass_t`  exception info to memory2
- `fwd_req`  out  `forward_req_t`  forwarding source for decode
- `dc_req`  out  `dcache_req_t`  fields: valid, addr, is_store, wstrb[3:0], wdata[31:0], is_cac
- `dc_ready`  in  1  D-cache accepts `dc_req` this cycle

## Operation
- **Stage register** (`pass_in_r`, `excp_pass_in_r`):
  - On `rst` or `flush_i`, both valid bits clear.
  - Otherwise, when `~stall_o`, the register loads `pass_in` / `excp_pass_in`.
- **Address**: `addr = pass_in_r.ex_out`.
- **ALE**:
  - HALF is misaligned when `addr[0]`; WORD is misaligned when `addr[1:0] != 0`; BYTE never faults.
  - ALE applies only when `is_mem` and the incoming exception is not valid. An earlier exception always wins.
  - On ALE: `excp_pass_out.valid = 1`, `ecode = ECODE_ALE`, `badv = addr`.
- **Strobe**:
  - BYTE: `4'b0001 << addr[1:0]`
  - HALF: `4'b0011 << addr[1:0]`
  - WORD: `4'b1111`
- **Store data**:
  - BYTE: `{4{rkd[7:0]}}`
  - HALF: `{2{rkd[15:0]}}`
  - WORD: `rkd`
- **`mem_do`** = `valid & is_mem & ~any_excp`.
- **Request issue**: `dc_req.valid = mem_do & ~issued`. The request fields stay stable while valid.
- **`issued` flag**:
  - Set on the handshake (`dc_req.valid & dc_ready`) when `stall_i` is high.
  - Cleared when the stage advances (`~stall_o`), on flush, or on reset.
  - Purpose: a request is never re-issued while memory2 holds the stage.
- **`dc_wait`** = `dc_req.valid & ~dc_ready`.
- **`pass_out`**:
  - `valid = pass_in_r.valid & ~stall_o`.
  - Carries pc, rd, is_wr_rd, is_wr_rd_pc_plus4, pc_plus4, ex_out, is_mem, is_store, is_signed, byte_type, `addr[1:0]`, csr fields, tlb_op, is_ertn.
  - Also carries `mem_issued`, which is high when this instruction's request was accepted.
- **`excp_pass_out.valid`** is gated by `pass_out.valid`.
- **Forwarding**:
  - `fwd_req.valid = valid & is_wr_rd & rd != 0 & ~any_excp`.
  - `fwd_req.idx = rd`.
  - `fwd_req.data_valid = ~(is_mem & ~is_store)`.
  - `fwd_req.data = is_wr_rd_pc_plus4 ? pc_plus4 : ex_out`.

## Timing
- **Reset**: every output is 0. In particular `dc_req.valid`, `pass_out.valid`, `excp_pass_out.valid`, `fwd_req.valid` and `stall_o` are all low.
- **Issue latency**: the request is issued combinationally in the first cycle the instruction occupies the stage.
  - With `dc_ready = 1`, it costs 0 stall cycles.
  - Each cycle of `dc_ready = 0` adds one cycle of `stall_o`.
- **Handshake and stalls**:
  - Withdrawing a request that has not been accepted is legal. It occurs only on flush.
  - Simultaneous `stall_i` and handshake: the request is accepted once, `issued` sets, and `dc_req.valid` is 0 from the next cycle until the stage advances.
- **Flush**:
  - Flush while waiting for `dc_ready`: the request drops next cycle and the cache sees no transaction.
  - Flush after acceptance: memory2 discards the response.
- **Non-memory instructions**: zero added latency; stall is driven by `stall_i` alone.
- **ALE / prior exception**: no request is issued, so the stage adds no stall cycles.

## Structure
- **Add to `cpu_defs`**: `dcache_req_t`, `memory1_memory2_pass_t`, `byte_type_t` (BYTE/HALF/WORD), and constant `ECODE_ALE`.
- **Sub-module `mem_align`**: combinational. Inputs: byte_type, addr[1:0], rkd. Outputs: wstrb, wdata, misaligned. memory2 reuses the same encoding for load extraction.
- **Top**: stage register, `issued` flag, handshake and forwarding logic.

## Test plan
- **Aligned store, ready**: SW at addr 0x1000, rkd = 0xDEADBEEF, `dc_ready = 1` → one cycle with `dc_req.valid = 1`, `wstrb = 4'b1111`, `wdata = 0xDEADBEEF`, `stall_o = 0`, `pass_out.valid = 1`.
- **Byte store, slow cache**: SB at addr 0x1003, rkd = 0x12345678, `dc_ready` low for 3 cycles → `stall_o` high for exactly 3 cycles, `wstrb = 4'b1000`, `wdata = 0x78787878`, one handshake.
- **Misaligned load**: LD.H at addr 0x2001 → no `dc_req.valid`, `excp_pass_out.valid = 1`, `ecode = 0x09`, `badv = 0x2001`, `fwd_req.valid = 0`.
- **Downstream stall after accept**: LD.W accepted with `stall_i` high for 4 cycles → exactly 1 handshake, `dc_req.valid = 0` for the remaining cycles, `pass_out.mem_issued = 1` on release.
- **Flush during wait**: LD.W with `dc_ready = 0`, `flush_i` pulsed → next cycle `dc_req.valid = 0`, `pass_out.valid = 0`, zero handshakes.
- **Load forwarding**: LD.W to rd = 5 → `fwd_req.valid = 1`, `idx = 5`, `data_valid = 0`. ADD to rd = 0 → `fwd_req.valid = 0`. Reset asserted mid-wait → all outputs 0 next cycle.
